// File: rtl/gpio_shr_driver.sv
// gpio_shr_driver: shifts a WIDTH-bit frame into a 74HC595-style chain, then latches.
// Optional SHR_CTRL_OE_BLANK_EN: chain outputs blanked (OE_N=1) while a frame updates.
module gpio_shr_driver #(
  parameter int WIDTH     = 34,
  parameter int DIV       = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             DATA_VALID,
  output logic             DATA_READY,
  output logic             BUSY,
  output logic             SHR_SCLK,
  output logic             SHR_SDATA,
  output logic             SHR_LATCH,
  output logic             SHR_OE_N
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int PW = $clog2(DIV) + 1;
  localparam logic [BW-1:0] BIT_LOAD = BW'(WIDTH);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [PW-1:0] PH_LAST  = PW'(DIV - 1);
  localparam logic [PW-1:0] PH_ONE   = PW'(1);
`ifdef SHR_CTRL_OE_BLANK_EN
  localparam bit OE_BLANK = 1'b1;
`else
  localparam bit OE_BLANK = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] shreg, shreg_d;
  logic [BW-1:0]    bit_cnt, bit_cnt_d;
  logic [PW-1:0]    phase, phase_d;
  logic             sclk, sclk_d;
  logic             oe_n, oe_n_d;
  logic             ph_end;

  assign ph_end = (phase == PH_LAST);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      phase   <= '0;
      sclk    <= 1'b0;
      oe_n    <= 1'b1;
    end else begin
      state   <= state_d;
      shreg   <= shreg_d;
      bit_cnt <= bit_cnt_d;
      phase   <= phase_d;
      sclk    <= sclk_d;
      oe_n    <= oe_n_d;
    end
  end

  always_comb begin
    state_d   = state;
    shreg_d   = shreg;
    bit_cnt_d = bit_cnt;
    phase_d   = phase;
    sclk_d    = sclk;
    oe_n_d    = oe_n;
    unique case (state)
      IDLE: begin
        if (DATA_VALID) begin
          state_d   = SHIFT;
          shreg_d   = DATA_IN;
          bit_cnt_d = BIT_LOAD;
          phase_d   = '0;
          sclk_d    = 1'b0;
          if (OE_BLANK) oe_n_d = 1'b1;
        end
      end
      SHIFT: begin
        if (!ph_end) begin
          phase_d = phase + PH_ONE;
        end else begin
          phase_d = '0;
          if (!sclk) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d    = 1'b0;
            bit_cnt_d = bit_cnt - BIT_ONE;
            // last bit stays at the head so SDATA holds it through LATCH
            if (bit_cnt == BIT_ONE)
              state_d = LATCH;
            else
              shreg_d = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
          end
        end
      end
      LATCH: begin
        if (!ph_end) begin
          phase_d = phase + PH_ONE;
        end else begin
          phase_d = '0;
          state_d = IDLE;
          oe_n_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign DATA_READY = (state == IDLE);
  assign BUSY       = ~DATA_READY;
  assign SHR_SCLK   = sclk;
  assign SHR_SDATA  = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
  assign SHR_LATCH  = (state == LATCH);
  assign SHR_OE_N   = oe_n;

endmodule

// File: tb/tb_gpio_shr_driver.sv
// tb_gpio_shr_driver: directed frames on two configurations of gpio_shr_driver,
// with a serial chain model capturing SDATA on SCLK rises and latching on LATCH.
module tb_gpio_shr_driver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

`ifdef SHR_CTRL_OE_BLANK_EN
  localparam bit OE_EXP = 1'b1;
`else
  localparam bit OE_EXP = 1'b0;
`endif

  // a: WIDTH=34 DIV=4 MSB first
  logic [33:0] a_data = '0;
  logic a_valid = 1'b0;
  logic a_ready, a_busy, a_sclk, a_sdata, a_latch, a_oe_n;
  // b: WIDTH=8 DIV=1 LSB first
  logic [7:0] b_data = '0;
  logic b_valid = 1'b0;
  logic b_ready, b_busy, b_sclk, b_sdata, b_latch, b_oe_n;

  gpio_shr_driver #(.WIDTH(34), .DIV(4), .MSB_FIRST(1'b1)) u_a (
    .CLOCK_50(clk), .RESET_N(rst_n),
    .DATA_IN(a_data), .DATA_VALID(a_valid),
    .DATA_READY(a_ready), .BUSY(a_busy),
    .SHR_SCLK(a_sclk), .SHR_SDATA(a_sdata),
    .SHR_LATCH(a_latch), .SHR_OE_N(a_oe_n)
  );

  gpio_shr_driver #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b0)) u_b (
    .CLOCK_50(clk), .RESET_N(rst_n),
    .DATA_IN(b_data), .DATA_VALID(b_valid),
    .DATA_READY(b_ready), .BUSY(b_busy),
    .SHR_SCLK(b_sclk), .SHR_SDATA(b_sdata),
    .SHR_LATCH(b_latch), .SHR_OE_N(b_oe_n)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // chain models (never reset: a real 74HC595 chain keeps its contents)
  logic [33:0] a_chain = '0, a_latched = '0;
  logic [7:0]  b_chain = '0, b_latched = '0;
  logic a_sclk_q = 1'b0, a_latch_q = 1'b0, b_sclk_q = 1'b0, b_latch_q = 1'b0;
  int a_pulses = 0, a_lpulses = 0, b_pulses = 0, b_lpulses = 0;
  logic overlap = 1'b0;

  always @(negedge clk) begin
    a_sclk_q  <= a_sclk;
    a_latch_q <= a_latch;
    b_sclk_q  <= b_sclk;
    b_latch_q <= b_latch;
    if (a_sclk && !a_sclk_q) begin
      a_chain  <= {a_chain[32:0], a_sdata};
      a_pulses <= a_pulses + 1;
    end
    if (a_latch && !a_latch_q) begin
      a_latched <= a_chain;
      a_lpulses <= a_lpulses + 1;
    end
    if (b_sclk && !b_sclk_q) begin
      b_chain  <= {b_sdata, b_chain[7:1]};
      b_pulses <= b_pulses + 1;
    end
    if (b_latch && !b_latch_q) begin
      b_latched <= b_chain;
      b_lpulses <= b_lpulses + 1;
    end
    if ((a_sclk && a_latch) || (b_sclk && b_latch)) overlap <= 1'b1;
  end

  localparam logic [33:0] DA = 34'h2_AAAA_5555;
  localparam logic [33:0] DB = 34'h1_2345_6789;
  localparam logic [33:0] DC = 34'h3_0F0F_F0F0;
  localparam logic [33:0] DD = 34'h0_FFFF_FFFF;

  int first_latch, latch_cnt, rdy_low, first_rdy, p0, l0;
  logic oe_lo, oe_bad;

  initial begin
    // reset and idle
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_ready", a_ready, 1);
    check("rst_busy", a_busy, 0);
    check("rst_sclk", a_sclk, 0);
    check("rst_sdata", a_sdata, 0);
    check("rst_latch", a_latch, 0);
    check("rst_oe_n", a_oe_n, 1);
    check("rst_pulses", a_pulses, 0);
    check("rst_b_oe_sclk", {b_ready, b_oe_n, b_sclk, b_latch}, 4'b1100);

    // frame DA on a, MSB first, DIV=4
    p0 = a_pulses;
    a_data = DA;
    a_valid = 1'b1;
    @(posedge clk);
    first_latch = 0; latch_cnt = 0; rdy_low = 0; first_rdy = 0; oe_lo = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == 1) begin
        a_valid = 1'b0;
        check("a_first_sdata", a_sdata, 1);
        check("a_busy", a_busy, 1);
      end
      if (k == 4) check("a_sclk_k4", a_sclk, 0);
      if (k == 5) check("a_sclk_k5", a_sclk, 1);
      if (k == 9) check("a_sclk_k9", a_sclk, 0);
      if (a_latch) begin
        latch_cnt++;
        if (first_latch == 0) first_latch = k;
      end
      if (!a_ready) rdy_low++;
      else if (first_rdy == 0) first_rdy = k;
      if (!a_ready && !a_oe_n) oe_lo = 1'b1;
    end
    check("a_latch_rise", first_latch, 273);
    check("a_latch_len", latch_cnt, 4);
    check("a_ready_low", rdy_low, 276);
    check("a_ready_back", first_rdy, 277);
    check("a_pulses", a_pulses - p0, 34);
    check("a_chain", a_chain, DA);
    check("a_latched", a_latched, DA);
    check("a_oe_first_frame", oe_lo, 0);
    check("a_oe_after", a_oe_n, 0);

    // frame 8'h01 on b, LSB first, DIV=1
    p0 = b_pulses;
    b_data = 8'h01;
    b_valid = 1'b1;
    @(posedge clk);
    first_latch = 0; rdy_low = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        b_valid = 1'b0;
        check("b_first_sdata", b_sdata, 1);
      end
      if (k == 3) check("b_second_sdata", b_sdata, 0);
      if (b_latch && first_latch == 0) first_latch = k;
      if (!b_ready) rdy_low++;
    end
    check("b_frame_len", rdy_low, 17);
    check("b_latch_rise", first_latch, 17);
    check("b_pulses", b_pulses - p0, 8);
    check("b_latched", b_latched, 8'h01);
    check("b_oe_after", b_oe_n, 0);

    // back-to-back on a: VALID held, data changes mid-frame
    l0 = a_lpulses;
    a_data = DB;
    a_valid = 1'b1;
    @(posedge clk);
    oe_bad = 1'b0;
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      if (k == 140) a_data = DC;
      if (k == 277) begin
        check("b2b_idle_ready", a_ready, 1);
        check("b2b_first_word", a_latched, DB);
        check("b2b_idle_oe", a_oe_n, 0);
      end
      if (k == 278) begin
        check("b2b_second_accept", a_ready, 0);
        a_valid = 1'b0;
      end
      if (k >= 278 && k <= 553 && a_oe_n !== OE_EXP) oe_bad = 1'b1;
    end
    check("b2b_oe_second", oe_bad, 0);
    check("b2b_second_word", a_latched, DC);
    check("b2b_lpulses", a_lpulses - l0, 2);
    check("b2b_ready_end", a_ready, 1);

    // reset during bit 10 of a frame
    l0 = a_lpulses;
    a_data = DD;
    a_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 85; k++) begin
      @(negedge clk);
      if (k == 1) a_valid = 1'b0;
    end
    check("mid_sclk_bit10", a_sclk, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", a_ready, 1);
    check("mid_rst_busy", a_busy, 0);
    check("mid_rst_sclk", a_sclk, 0);
    check("mid_rst_sdata", a_sdata, 0);
    check("mid_rst_latch", a_latch, 0);
    check("mid_rst_oe_n", a_oe_n, 1);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("mid_rst_no_latch", a_lpulses - l0, 0);
    check("mid_rst_kept_word", a_latched, DC);
    check("mid_rst_idle", {a_ready, a_sclk, a_latch}, 3'b100);
    check("sclk_latch_overlap", overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
